// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants for the multiplier-sharing arbiter and the Seq_Mult it drives.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// MULT_LAT lives here so the Seq_Mult latency and the arbiter's wait time
// are set from a single constant.
package mult_share_arbiter_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MULT_LAT = 5;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_rr_pick.sv
// Two-way round-robin pick between two level requests.
// Latency: combinational.
// Backpressure: none; the caller acts on the grant only when it can accept.
//
// Ports:
//   i_req0, i_req1 : request levels
//   i_last         : requester served most recently
//   o_grant        : winning requester (0 or 1), meaningful when o_any
//   o_any          : at least one request present
module mult_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_grant,
  output logic o_any
);

  // With both requesting, whoever was not served last wins.
  // Otherwise the sole requester wins; with only req0 (or none) this is 0.
  always_comb begin
    o_any   = i_req0 | i_req1;
    o_grant = 1'b0;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last;
    end else if (i_req1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one Seq_Mult between two requesters with round-robin arbitration.
// Latency: req seen in IDLE at cycle t -> done pulse at cycle t+2+MULT_LAT.
// Backpressure: requests are levels; a losing or late requester simply stays high until served.
//
// Ports:
//   clk, clr              : clock, synchronous active-high reset
//   req0/a0/b0            : requester 0 request level and operands
//   req1/a1/b1            : requester 1 request level and operands
//   done0, done1          : one-cycle completion pulses per requester
//   p_out, owner, busy    : last captured product, its requester, FSM not idle
//   mult_go/mult_a/mult_b : start pulse and registered operands to Seq_Mult
//   mult_p                : product from Seq_Mult
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MULT_LAT = DEF_MULT_LAT
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 done0,
  output logic                 done1,
  output logic [2*WIDTH-1:0]   p_out,
  output logic                 owner,
  output logic                 busy,
  output logic                 mult_go,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_p
);

  localparam int CW = $clog2(MULT_LAT) + 1;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_last;

  logic           w_grant;
  logic           w_any;

  mult_rr_pick u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // All outputs are registered: each is set on the transition into the
  // state where it must be visible, so it lines up with that state.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_last  <= 1'b1;        // requester 0 wins the first contention
      done0   <= 1'b0;
      done1   <= 1'b0;
      p_out   <= '0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      mult_go <= 1'b0;
      mult_a  <= '0;
      mult_b  <= '0;
    end else begin
      done0   <= 1'b0;
      done1   <= 1'b0;
      mult_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            // Operands are sampled only here; later changes are ignored.
            mult_a  <= w_grant ? a1 : a0;
            mult_b  <= w_grant ? b1 : b0;
            owner   <= w_grant;
            r_last  <= w_grant;
            mult_go <= 1'b1;
            busy    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_count <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // WAIT lasts exactly MULT_LAT cycles; mult_p is valid in the last one.
          if (r_count == CW'(MULT_LAT - 1)) begin
            p_out   <= mult_p;
            done0   <= ~owner;
            done1   <= owner;
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int L = DEF_MULT_LAT;

  logic           clk = 1'b0;
  logic           clr;
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           done0, done1, owner, busy, mult_go;
  logic [2*W-1:0] p_out, mult_p;
  logic [W-1:0]   mult_a, mult_b;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W), .MULT_LAT(L)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .p_out(p_out), .owner(owner), .busy(busy),
    .mult_go(mult_go), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p)
  );

  // Seq_Mult stand-in: product valid MULT_LAT cycles after the go cycle,
  // a filler pattern before that so early capture is visible.
  logic [2*W-1:0] m_prod;
  int             m_rem;
  logic           m_armed;
  always @(posedge clk) begin
    if (clr) begin
      m_prod <= '0; m_rem <= 0; m_armed <= 1'b0;
    end else if (mult_go) begin
      m_prod  <= {{W{1'b0}}, mult_a} * {{W{1'b0}}, mult_b};
      m_rem   <= L - 1;
      m_armed <= 1'b1;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
    end
  end
  assign mult_p = (m_armed && m_rem == 0) ? m_prod : 8'hA5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             who;
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the next expected result.
  logic prev_go = 1'b0;
  always @(negedge clk) begin
    if (!clr) begin
      if (mult_go) begin
        chk("go_while_busy", 32'(busy), 32'd1);
        chk("go_single_cycle", 32'(prev_go), 32'd0);
      end
      if (done0 || done1) begin
        chk("done_exclusive", 32'(done0 & done1), 32'd0);
        chk("done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done_who", 32'(done1), e.who);
          chk("owner", 32'(owner), e.who);
          chk("p_out", 32'(p_out), 32'(e.prod));
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
    prev_go <= mult_go;
  end

  task automatic push(input int who, input logic [2*W-1:0] prod, input int c);
    exp_t e;
    e.who = who; e.prod = prod; e.cyc = c;
    sb.push_back(e);
  endtask

  // Requester behaviour: raise req with operands, drop it where done is seen.
  task automatic do_op(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
    logic got;
    got = 1'b0;
    if (who == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else          begin req1 = 1'b1; a1 = a; b1 = b; end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = (who == 0) ? done0 : done1;
    end
    chk("op_completes", 32'(got), 32'd1);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic reset_dut(input int n);
    clr = 1'b1;
    repeat (n) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done0"}, 32'(done0), 32'd0);
    chk({tag, "_done1"}, 32'(done1), 32'd0);
    chk({tag, "_go"}, 32'(mult_go), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_p_out"}, 32'(p_out), 32'd0);
    chk({tag, "_mult_a"}, 32'(mult_a), 32'd0);
    chk({tag, "_mult_b"}, 32'(mult_b), 32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, k;
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    clr = 1'b0;

    // Reset during WAIT aborts silently.
    @(negedge clk);
    req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    clr = 1'b1; req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("abort");
    clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle_after", 32'(busy), 32'd0);

    // Single op: 3*5.
    t = cyc;
    push(0, 8'h0F, t + 2 + L);
    fork
      do_op(0, 4'd3, 4'd5);
      begin
        @(negedge clk);
        chk("single_go", 32'(mult_go), 32'd1);
        chk("single_mult_a", 32'(mult_a), 32'd3);
        chk("single_mult_b", 32'(mult_b), 32'd5);
        @(negedge clk);
        chk("single_go_low", 32'(mult_go), 32'd0);
      end
    join
    wait_drain(20);
    repeat (2) @(negedge clk);

    // Contention from reset: requester 0 first, then 1.
    reset_dut(2);
    t = cyc;
    push(0, 8'h3F, t + 2 + L);
    push(1, 8'hE1, t + 2 + L + 1 + 2 + L);
    fork
      do_op(0, 4'd7, 4'd9);
      do_op(1, 4'd15, 4'd15);
    join
    wait_drain(20);
    repeat (2) @(negedge clk);

    // Fairness: both held for four ops -> 0,1,0,1.
    t = cyc;
    for (int i = 0; i < 4; i++)
      push(i % 2, (i % 2 == 0) ? 8'h02 : 8'h0C, t + 2 + L + i * (3 + L));
    a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4;
    req0 = 1'b1; req1 = 1'b1;
    n = 0; k = 0;
    while (n < 4 && k < 200) begin
      @(negedge clk);
      k++;
      if (done0 || done1) n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("fair_op_count", n, 4);
    wait_drain(20);
    repeat (2) @(negedge clk);

    // Operand change during WAIT is ignored.
    t = cyc;
    push(0, 8'h08, t + 2 + L);
    fork
      do_op(0, 4'd2, 4'd4);
      begin
        repeat (3) @(negedge clk);
        a0 = 4'd9;
      end
    join
    wait_drain(20);
    repeat (2) @(negedge clk);

    // Zero operand.
    t = cyc;
    push(1, 8'h00, t + 2 + L);
    do_op(1, 4'd0, 4'd15);
    wait_drain(20);
    repeat (2) @(negedge clk);

    // req1 dropped mid-operation: still completes.
    t = cyc;
    push(1, 8'h2A, t + 2 + L);
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd7;
    repeat (4) @(negedge clk);
    req1 = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n == 0; i++) begin
      @(negedge clk);
      if (done1) n = 1;
    end
    chk("drop_done1_seen", n, 1);
    @(negedge clk);
    chk("drop_busy_after", 32'(busy), 32'd0);
    wait_drain(20);
    repeat (10) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
